// File: rtl/video_sync_receiver.sv
// Video timing receiver: measures line/frame periods and visible extents from a
// sync generator, tracks pixel/line position, and locks once the timing repeats.
module video_sync_receiver #(
   parameter int LOCK_FRAMES = 2
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_hsync,
   input  logic       i_vsync,
   input  logic       i_visible,
   output logic       o_de,
   output logic [9:0] o_hpos,
   output logic [9:0] o_vpos,
   output logic [9:0] o_line_len,
   output logic [9:0] o_frame_lines,
   output logic [9:0] o_hvis,
   output logic [9:0] o_vvis,
   output logic       o_frame_start,
   output logic       o_locked,
   output logic       o_error
);
   localparam logic [9:0] SAT      = 10'd1023;
   localparam logic [3:0] LOCK_TGT = 4'(LOCK_FRAMES - 1);

   typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;
   state_t state_q, state_d;

   logic       hs1_q, hs2_q, vs1_q, vs2_q, vis1_q;
   logic [9:0] h_cnt_q, h_cnt_d, de_cnt_q, de_cnt_d, v_cnt_q, v_cnt_d;
   logic [9:0] line_len_q, line_len_d, frame_lines_q, frame_lines_d;
   logic [9:0] hvis_q, hvis_d, vvis_q, vvis_d, vpos_q, vpos_d;
   logic [9:0] ref_len_q, ref_len_d, ref_lines_q, ref_lines_d;
   logic [3:0] match_q, match_d;
   logic       seen_h_q, seen_h_d, fs_q, err_q, err_d;
   logic       hs_rise, vs_rise, h_sat;
   logic [9:0] de_line;

   function automatic logic [9:0] inc_sat(input logic [9:0] v);
      return (v == SAT) ? v : v + 10'd1;
   endfunction

   assign hs_rise = hs1_q & ~hs2_q;
   assign vs_rise = vs1_q & ~vs2_q;
   assign h_sat   = (h_cnt_q == SAT);
   // visible pixels of the line so far, including the current cycle
   assign de_line = vis1_q ? inc_sat(de_cnt_q) : de_cnt_q;

   always_comb begin : meas
      h_cnt_d       = hs_rise ? 10'd1 : inc_sat(h_cnt_q);
      de_cnt_d      = de_line;
      v_cnt_d       = v_cnt_q;
      line_len_d    = line_len_q;
      frame_lines_d = frame_lines_q;
      hvis_d        = hvis_q;
      vvis_d        = vvis_q;
      vpos_d        = vpos_q;
      if (hs_rise) begin
         if (seen_h_q) line_len_d = h_cnt_q;
         hvis_d   = de_line;
         de_cnt_d = '0;
         v_cnt_d  = inc_sat(v_cnt_q);
         // vvis only latches on blank lines that follow visible ones, so the
         // blank lines after vsync (vpos already cleared) keep the frame's count
         if (de_line != '0) vpos_d = inc_sat(vpos_q);
         else if (vpos_q != '0) vvis_d = vpos_q;
      end
      if (vs_rise) begin
         frame_lines_d = v_cnt_d;
         v_cnt_d       = '0;
         vpos_d        = '0;
      end
   end

   always_comb begin : lock_fsm
      state_d     = state_q;
      match_d     = match_q;
      ref_len_d   = ref_len_q;
      ref_lines_d = ref_lines_q;
      err_d       = 1'b0;
      case (state_q)
         SEARCH: begin
            if (vs_rise) begin
               state_d     = TRACK;
               match_d     = '0;
               ref_len_d   = '0;
               ref_lines_d = '0;
            end
         end
         TRACK: begin
            if (h_sat) begin
               state_d = SEARCH;
            end else if (vs_rise) begin
               if (line_len_d == ref_len_q && frame_lines_d == ref_lines_q) begin
                  if (match_q != 4'hF) match_d = match_q + 4'd1;
               end else begin
                  match_d = '0;
               end
               ref_len_d   = line_len_d;
               ref_lines_d = frame_lines_d;
               // a saturated line length is never a valid timing to lock onto
               if (match_d >= LOCK_TGT && line_len_d != SAT) state_d = LOCKED;
            end
         end
         LOCKED: begin
            if (h_sat || (hs_rise && h_cnt_q != ref_len_q) ||
                (vs_rise && frame_lines_d != ref_lines_q)) begin
               err_d   = 1'b1;
               state_d = SEARCH;
            end
         end
         default: state_d = SEARCH;
      endcase
   end

   assign seen_h_d = (state_d == SEARCH && state_q != SEARCH) ? 1'b0 : (seen_h_q | hs_rise);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= SEARCH;
      else          state_q <= state_d;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         hs1_q         <= 1'b0;
         hs2_q         <= 1'b0;
         vs1_q         <= 1'b0;
         vs2_q         <= 1'b0;
         vis1_q        <= 1'b0;
         h_cnt_q       <= '0;
         de_cnt_q      <= '0;
         v_cnt_q       <= '0;
         line_len_q    <= '0;
         frame_lines_q <= '0;
         hvis_q        <= '0;
         vvis_q        <= '0;
         vpos_q        <= '0;
         ref_len_q     <= '0;
         ref_lines_q   <= '0;
         match_q       <= '0;
         seen_h_q      <= 1'b0;
         fs_q          <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         hs1_q         <= i_hsync;
         hs2_q         <= hs1_q;
         vs1_q         <= i_vsync;
         vs2_q         <= vs1_q;
         vis1_q        <= i_visible;
         h_cnt_q       <= h_cnt_d;
         de_cnt_q      <= de_cnt_d;
         v_cnt_q       <= v_cnt_d;
         line_len_q    <= line_len_d;
         frame_lines_q <= frame_lines_d;
         hvis_q        <= hvis_d;
         vvis_q        <= vvis_d;
         vpos_q        <= vpos_d;
         ref_len_q     <= ref_len_d;
         ref_lines_q   <= ref_lines_d;
         match_q       <= match_d;
         seen_h_q      <= seen_h_d;
         fs_q          <= vs_rise;
         err_q         <= err_d;
      end
   end

   assign o_de          = vis1_q;
   assign o_hpos        = (de_cnt_q == '0) ? '0 : (vis1_q ? de_cnt_q : de_cnt_q - 10'd1);
   assign o_vpos        = vpos_q;
   assign o_line_len    = line_len_q;
   assign o_frame_lines = frame_lines_q;
   assign o_hvis        = hvis_q;
   assign o_vvis        = vvis_q;
   assign o_frame_start = fs_q;
   assign o_locked      = (state_q == LOCKED);
   assign o_error       = err_q;

endmodule

// File: tb/tb_video_sync_receiver.sv
// Directed bench for video_sync_receiver: 20x10 timing with 10x3 visible, plus
// stretch, stall, coincident-sync and reset cases; a LOCK_FRAMES=1 twin runs alongside.
module tb_video_sync_receiver;
   logic       i_clk = 1'b0;
   logic       i_rst_n, i_hsync, i_vsync, i_visible;
   logic       o_de, o_frame_start, o_locked, o_error;
   logic [9:0] o_hpos, o_vpos, o_line_len, o_frame_lines, o_hvis, o_vvis;
   logic       d1_de, d1_frame_start, d1_locked, d1_error;
   logic [9:0] d1_hpos, d1_vpos, d1_line_len, d1_frame_lines, d1_hvis, d1_vvis;
   int checks = 0, failures = 0, err_cnt = 0, fs_cnt = 0;
   int e0, f0;

   always #5 i_clk = ~i_clk;

   video_sync_receiver #(.LOCK_FRAMES(2)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_hsync(i_hsync), .i_vsync(i_vsync),
      .i_visible(i_visible), .o_de(o_de), .o_hpos(o_hpos), .o_vpos(o_vpos),
      .o_line_len(o_line_len), .o_frame_lines(o_frame_lines), .o_hvis(o_hvis),
      .o_vvis(o_vvis), .o_frame_start(o_frame_start), .o_locked(o_locked),
      .o_error(o_error));

   video_sync_receiver #(.LOCK_FRAMES(1)) dut1 (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_hsync(i_hsync), .i_vsync(i_vsync),
      .i_visible(i_visible), .o_de(d1_de), .o_hpos(d1_hpos), .o_vpos(d1_vpos),
      .o_line_len(d1_line_len), .o_frame_lines(d1_frame_lines), .o_hvis(d1_hvis),
      .o_vvis(d1_vvis), .o_frame_start(d1_frame_start), .o_locked(d1_locked),
      .o_error(d1_error));

   always @(negedge i_clk) begin
      if (o_error === 1'b1) err_cnt <= err_cnt + 1;
      if (o_frame_start === 1'b1) fs_cnt <= fs_cnt + 1;
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_de"},    32'(o_de), 32'd0);
      chk({tag, "_hpos"},  32'(o_hpos), 32'd0);
      chk({tag, "_vpos"},  32'(o_vpos), 32'd0);
      chk({tag, "_len"},   32'(o_line_len), 32'd0);
      chk({tag, "_lines"}, 32'(o_frame_lines), 32'd0);
      chk({tag, "_hvis"},  32'(o_hvis), 32'd0);
      chk({tag, "_vvis"},  32'(o_vvis), 32'd0);
      chk({tag, "_fs"},    32'(o_frame_start), 32'd0);
      chk({tag, "_lock"},  32'(o_locked), 32'd0);
      chk({tag, "_err"},   32'(o_error), 32'd0);
   endtask

   // One line: visible p0..9, hsync high p13..16, len 20 (21 = one extra border clock)
   task automatic send_line(input int l, input bit vs, input bit chk_en, input int len);
      for (int p = 0; p < len; p++) begin
         i_visible = (l < 3) && (p < 10);
         i_hsync   = (p >= 13) && (p < 17);
         i_vsync   = vs;
         tick();
         if (chk_en) begin
            if (l < 3 && p < 10) begin
               chk("de", 32'(o_de), 32'd1);
               chk("hpos", 32'(o_hpos), 32'(p));
               chk("vpos", 32'(o_vpos), 32'(l));
            end
            if (vs && p < 3) chk("frame_start", 32'(o_frame_start), 32'(p == 1));
         end
      end
   endtask

   task automatic frame(input int first, input int last, input int stretch, input bit chk_en);
      for (int l = first; l <= last; l++)
         send_line(l, l == 6, chk_en, (l == stretch) ? 21 : 20);
   endtask

   task automatic idle(input int n);
      i_hsync = 1'b0; i_vsync = 1'b0; i_visible = 1'b0;
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic do_reset();
      i_rst_n = 1'b0;
      idle(3);
      i_rst_n = 1'b1;
   endtask

   initial begin
      i_rst_n = 1'b0; i_hsync = 1'b0; i_vsync = 1'b0; i_visible = 1'b0;
      idle(3);
      chk_zero("reset");
      i_rst_n = 1'b1;

      // nominal: lock after 3rd vsync rise (twin after 2nd)
      frame(0, 9, -1, 1);
      chk("lock_f1", 32'(o_locked), 32'd0);
      chk("lock1_f1", 32'(d1_locked), 32'd0);
      frame(0, 9, -1, 1);
      chk("lock_f2", 32'(o_locked), 32'd0);
      chk("lock1_f2", 32'(d1_locked), 32'd1);
      frame(0, 9, -1, 1);
      chk("lock_f3", 32'(o_locked), 32'd1);
      frame(0, 1, -1, 1);
      chk("hvis", 32'(o_hvis), 32'd10);
      frame(2, 9, -1, 1);
      chk("line_len", 32'(o_line_len), 32'd20);
      chk("frame_lines", 32'(o_frame_lines), 32'd10);
      chk("vvis", 32'(o_vvis), 32'd3);
      chk("lock_f4", 32'(o_locked), 32'd1);
      chk("no_err_nominal", 32'(err_cnt), 32'd0);

      // one 21-clock line while locked
      e0 = err_cnt;
      frame(0, 9, 1, 0);
      chk("stretch_err", 32'(err_cnt - e0), 32'd1);
      chk("stretch_unlock", 32'(o_locked), 32'd0);
      frame(0, 9, -1, 0);
      chk("relock_1", 32'(o_locked), 32'd0);
      frame(0, 9, -1, 0);
      chk("relock_2", 32'(o_locked), 32'd1);
      chk("stretch_err_total", 32'(err_cnt - e0), 32'd1);

      // reset mid-frame while locked
      frame(0, 1, -1, 0);
      for (int p = 0; p < 6; p++) begin
         i_visible = 1'b1; i_hsync = 1'b0; i_vsync = 1'b0;
         tick();
      end
      chk("pre_rst_de", 32'(o_de), 32'd1);
      #2;
      i_rst_n = 1'b0;
      #1;
      chk_zero("async_rst");
      idle(3);
      i_rst_n = 1'b1;
      f0 = fs_cnt;
      frame(3, 5, -1, 1);
      chk("no_fs_before_vs", 32'(fs_cnt - f0), 32'd0);
      frame(6, 9, -1, 1);
      chk("fs_after_rst", 32'(fs_cnt - f0), 32'd1);
      chk("rst_no_lock", 32'(o_locked), 32'd0);

      // hsync stall: TRACK drops to SEARCH silently; 1023 never locks
      e0 = err_cnt;
      idle(1100);
      chk("stall_no_lock", 32'(o_locked), 32'd0);
      chk("stall_no_err", 32'(err_cnt - e0), 32'd0);
      i_hsync = 1'b1;
      for (int k = 0; k < 4; k++) tick();
      idle(1100);
      i_hsync = 1'b1;
      for (int k = 0; k < 4; k++) tick();
      i_hsync = 1'b0;
      tick();
      chk("sat_len", 32'(o_line_len), 32'd1023);
      for (int f = 0; f < 4; f++) begin
         i_vsync = 1'b1;
         for (int k = 0; k < 3; k++) tick();
         idle(20);
      end
      chk("sat_no_lock", 32'(o_locked), 32'd0);
      chk("sat_no_lock1", 32'(d1_locked), 32'd0);
      chk("sat_no_err", 32'(err_cnt - e0), 32'd0);

      // hsync and vsync rise together
      do_reset();
      send_line(0, 1'b0, 1'b0, 20);
      send_line(1, 1'b0, 1'b0, 21);
      send_line(2, 1'b0, 1'b0, 20);
      chk("pre_same_len", 32'(o_line_len), 32'd21);
      send_line(3, 1'b0, 1'b0, 13);
      i_visible = 1'b0; i_hsync = 1'b1; i_vsync = 1'b1;
      tick();
      tick();
      chk("same_fs", 32'(o_frame_start), 32'd1);
      chk("same_vpos", 32'(o_vpos), 32'd0);
      chk("same_len", 32'(o_line_len), 32'd20);
      chk("same_lines", 32'(o_frame_lines), 32'd4);
      chk("same_vvis", 32'(o_vvis), 32'd3);
      tick();
      chk("same_fs_end", 32'(o_frame_start), 32'd0);
      idle(5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
